// File: rtl/regular_defuzzification.sv
// Back end of the regular fuzzy datapath: deserialises NUM_TERMS membership
// degrees from the serial result stream and computes the centre-of-gravity
// crisp output floor(sum(mu_i*c_i) / sum(mu_i)).
// A sequential MAC is followed by a restoring divider.
module regular_defuzzification #(
    parameter int BIT_WIDTH = 10,
    parameter int NUM_TERMS = 4
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           io_start,
    input  logic                           io_inResultValid,
    input  logic                           io_inResult,
    input  logic [NUM_TERMS*BIT_WIDTH-1:0] io_centers,
    output logic                           io_busy,
    output logic                           io_outValid,
    output logic [BIT_WIDTH-1:0]           io_outCrisp,
    output logic                           io_outZero
);

    localparam int LOG_T  = $clog2(NUM_TERMS);
    localparam int NUM_W  = 2*BIT_WIDTH + LOG_T;
    localparam int DEN_W  = BIT_WIDTH + LOG_T;
    localparam int BIT_CW = $clog2(BIT_WIDTH);
    localparam int MU_W   = NUM_TERMS*BIT_WIDTH;

    typedef enum logic [2:0] {
        IDLE,
        SHIFT,
        MAC,
        DIV,
        DONE
    } state_t;

    state_t              state_q, state_d;
    logic [BIT_CW-1:0]   bit_cnt;
    logic [LOG_T-1:0]    term_idx;
    logic [MU_W-1:0]     mu_sr;
    logic [NUM_W-1:0]    num;
    logic [DEN_W-1:0]    den;
    logic [BIT_WIDTH-1:0] crisp_q;
    logic                zero_q;

    logic                bit_last;
    logic                term_last;
    logic [BIT_WIDTH-1:0] mu_top;
    logic [BIT_WIDTH-1:0] center_cur;
    logic [NUM_W-1:0]    mac_prod;
    logic [DEN_W:0]      div_trial;
    logic [DEN_W:0]      div_diff;
    logic                div_ge;
    logic [DEN_W-1:0]    div_rem;
    logic [BIT_WIDTH-1:0] result_crisp;
    logic                result_zero;

    // Counter end conditions, MAC operands and one restoring-divide step.
    // The upper DEN_W bits of num serve as the partial remainder while the
    // lower BIT_WIDTH bits shift out dividend bits and shift in quotient bits.
    always_comb begin
        bit_last     = (bit_cnt == BIT_CW'(BIT_WIDTH-1));
        term_last    = (term_idx == LOG_T'(NUM_TERMS-1));
        mu_top       = mu_sr[MU_W-1 -: BIT_WIDTH];
        center_cur   = io_centers[term_idx*BIT_WIDTH +: BIT_WIDTH];
        mac_prod     = NUM_W'(mu_top) * NUM_W'(center_cur);
        div_trial    = {num[NUM_W-1:BIT_WIDTH], num[BIT_WIDTH-1]};
        div_diff     = div_trial - {1'b0, den};
        div_ge       = (div_trial >= {1'b0, den});
        div_rem      = div_ge ? div_diff[DEN_W-1:0] : div_trial[DEN_W-1:0];
        result_zero  = (den == '0);
        result_crisp = result_zero ? '0 : num[BIT_WIDTH-1:0];
    end

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; io_start from any state restarts the frame.
    always_comb begin
        state_d = state_q;
        if (io_start) begin
            state_d = SHIFT;
        end else begin
            case (state_q)
                IDLE:    state_d = IDLE;
                SHIFT:   if (io_inResultValid && bit_last && term_last) state_d = MAC;
                MAC:     if (term_last) state_d = DIV;
                DIV:     if (bit_last) state_d = DONE;
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Datapath: deserialise, multiply-accumulate, then divide in place.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            bit_cnt  <= '0;
            term_idx <= '0;
            mu_sr    <= '0;
            num      <= '0;
            den      <= '0;
        end else if (io_start) begin
            bit_cnt  <= '0;
            term_idx <= '0;
            num      <= '0;
            den      <= '0;
        end else begin
            case (state_q)
                SHIFT: begin
                    if (io_inResultValid) begin
                        mu_sr <= {mu_sr[MU_W-2:0], io_inResult};
                        if (bit_last) begin
                            bit_cnt  <= '0;
                            term_idx <= term_last ? '0 : term_idx + 1'b1;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end
                MAC: begin
                    num      <= num + mac_prod;
                    den      <= den + DEN_W'(mu_top);
                    mu_sr    <= mu_sr << BIT_WIDTH;
                    term_idx <= term_last ? '0 : term_idx + 1'b1;
                end
                DIV: begin
                    if (den != '0) begin
                        num <= {div_rem, num[BIT_WIDTH-2:0], div_ge};
                    end
                    bit_cnt <= bit_last ? '0 : bit_cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Held result registers, committed only when a DONE cycle is not aborted.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            crisp_q <= '0;
            zero_q  <= 1'b0;
        end else if (state_q == DONE && !io_start) begin
            crisp_q <= result_crisp;
            zero_q  <= result_zero;
        end
    end

    // The fresh result is presented during DONE itself so that busy drops the
    // cycle after io_outValid; an io_start in that cycle suppresses both the
    // pulse and the update, leaving the previous result visible.
    always_comb begin
        io_busy     = (state_q != IDLE);
        io_outValid = (state_q == DONE) && !io_start;
        io_outCrisp = io_outValid ? result_crisp : crisp_q;
        io_outZero  = io_outValid ? result_zero : zero_q;
    end

endmodule

// File: tb/tb_regular_defuzzification.sv
// Scoreboard bench for regular_defuzzification: the driver pushes hand-computed
// results when a frame's last bit is presented; the monitor pops on io_outValid.
module tb_regular_defuzzification;

    localparam int W = 10;
    localparam int N = 4;

    logic             clock;
    logic             reset;
    logic             io_start;
    logic             io_inResultValid;
    logic             io_inResult;
    logic [N*W-1:0]   io_centers;
    logic             io_busy;
    logic             io_outValid;
    logic [W-1:0]     io_outCrisp;
    logic             io_outZero;

    typedef struct {
        logic [W-1:0] crisp;
        logic         zero;
        int           when;
    } exp_t;

    exp_t exp_q[$];
    int   checks;
    int   errors;
    int   neg_cnt;
    bit   busy_chk;

    regular_defuzzification #(.BIT_WIDTH(W), .NUM_TERMS(N)) dut (
        .clock            (clock),
        .reset            (reset),
        .io_start         (io_start),
        .io_inResultValid (io_inResultValid),
        .io_inResult      (io_inResult),
        .io_centers       (io_centers),
        .io_busy          (io_busy),
        .io_outValid      (io_outValid),
        .io_outCrisp      (io_outCrisp),
        .io_outZero       (io_outZero)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    // Monitor: counts falling edges, pops the scoreboard on every output pulse.
    always @(negedge clock) begin
        exp_t e;
        neg_cnt = neg_cnt + 1;
        if (busy_chk) begin
            busy_chk = 1'b0;
            chk("busy_after_valid", int'(io_busy), 0);
        end
        if (io_outValid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid: got crisp=%0d zero=%0d expected no pulse",
                         io_outCrisp, io_outZero);
            end else begin
                e = exp_q.pop_front();
                chk("crisp", int'(io_outCrisp), int'(e.crisp));
                chk("zero", int'(io_outZero), int'(e.zero));
                chk("latency_edge", neg_cnt, e.when);
                busy_chk = 1'b1;
            end
        end
    end

    // Drives one frame (optionally truncated); junk valid data on the start
    // cycle must be ignored. Pushes the expectation when the last bit goes out:
    // the capturing edge follows the next falling edge, and the pulse is seen
    // on the 15th falling edge after it.
    task automatic send_frame(input logic [N*W-1:0] mus, input bit bubbles,
                              input int nbits, input bit push,
                              input logic [W-1:0] exp_c, input bit exp_z);
        @(posedge clock); #1;
        io_start = 1'b1;
        io_inResultValid = 1'b1;
        io_inResult = 1'b1;
        @(posedge clock); #1;
        io_start = 1'b0;
        for (int b = 0; b < nbits; b++) begin
            if (bubbles) begin
                repeat ($urandom_range(0, 2)) begin
                    io_inResultValid = 1'b0;
                    io_inResult = 1'($urandom);
                    @(posedge clock); #1;
                end
            end
            io_inResultValid = 1'b1;
            io_inResult = mus[N*W-1-b];
            if (b == nbits-1 && push) begin
                exp_q.push_back('{crisp: exp_c, zero: exp_z, when: neg_cnt + 16});
            end
            @(posedge clock); #1;
        end
        io_inResultValid = 1'b0;
        io_inResult = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 200; i++) begin
            if (exp_q.size() == 0 && !busy_chk) break;
            @(posedge clock);
        end
        if (exp_q.size() != 0 || busy_chk) begin
            checks++;
            errors++;
            $display("FAIL timeout: got %0d pending results expected 0", exp_q.size());
            exp_q.delete();
            busy_chk = 1'b0;
        end
        repeat (3) @(posedge clock);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_busy"}, int'(io_busy), 0);
        chk({tag, "_valid"}, int'(io_outValid), 0);
        chk({tag, "_crisp"}, int'(io_outCrisp), 0);
        chk({tag, "_zero"}, int'(io_outZero), 0);
    endtask

    localparam logic [N*W-1:0] C_A = {10'd400, 10'd300, 10'd200, 10'd100};
    localparam logic [N*W-1:0] C_B = {10'd700, 10'd500, 10'd300, 10'd100};
    localparam logic [N*W-1:0] C_C = {10'd1000, 10'd800, 10'd400, 10'd0};

    initial begin
        checks = 0;
        errors = 0;
        neg_cnt = 0;
        busy_chk = 1'b0;
        reset = 1'b0;
        io_start = 1'b0;
        io_inResultValid = 1'b0;
        io_inResult = 1'b0;
        io_centers = C_A;
        #12;
        check_reset_outputs("reset_state");
        reset = 1'b1;
        repeat (2) @(posedge clock);

        // Single active term: 1023*100/1023.
        send_frame({10'd1023, 10'd0, 10'd0, 10'd0}, 1'b0, N*W, 1'b1, 10'd100, 1'b0);
        wait_idle();

        // All terms active: 300000/1000.
        send_frame({10'd100, 10'd200, 10'd300, 10'd400}, 1'b0, N*W, 1'b1, 10'd300, 1'b0);
        wait_idle();

        // Asynchronous reset in the middle of shifting.
        send_frame({10'd1023, 10'd0, 10'd0, 10'd0}, 1'b0, 25, 1'b0, 10'd0, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        check_reset_outputs("reset_midframe");
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;
        repeat (2) @(posedge clock);

        // Two equal terms: 204800/1024, contiguous then with bubbles.
        io_centers = C_B;
        send_frame({10'd512, 10'd512, 10'd0, 10'd0}, 1'b0, N*W, 1'b1, 10'd200, 1'b0);
        wait_idle();
        send_frame({10'd512, 10'd512, 10'd0, 10'd0}, 1'b1, N*W, 1'b1, 10'd200, 1'b0);
        wait_idle();

        // 40000/400, then an all-zero frame.
        io_centers = C_C;
        send_frame({10'd300, 10'd100, 10'd0, 10'd0}, 1'b0, N*W, 1'b1, 10'd100, 1'b0);
        wait_idle();
        send_frame({10'd0, 10'd0, 10'd0, 10'd0}, 1'b0, N*W, 1'b1, 10'd0, 1'b1);
        wait_idle();

        // Restart after 17 bits; only the second frame reports.
        io_centers = C_B;
        send_frame({10'd1023, 10'd1023, 10'd0, 10'd0}, 1'b0, 17, 1'b0, 10'd0, 1'b0);
        send_frame({10'd512, 10'd512, 10'd0, 10'd0}, 1'b0, N*W, 1'b1, 10'd200, 1'b0);
        chk("held_zero_during_frame", int'(io_outZero), 1);
        chk("held_crisp_during_frame", int'(io_outCrisp), 0);
        wait_idle();

        // Reset while dividing: no pulse, then a clean frame.
        io_centers = C_C;
        send_frame({10'd300, 10'd100, 10'd0, 10'd0}, 1'b0, N*W, 1'b0, 10'd0, 1'b0);
        repeat (7) @(posedge clock);
        #2;
        reset = 1'b0;
        #1;
        check_reset_outputs("reset_in_div");
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;
        repeat (30) @(posedge clock);
        send_frame({10'd300, 10'd100, 10'd0, 10'd0}, 1'b0, N*W, 1'b1, 10'd100, 1'b0);
        wait_idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got no completion expected finish before time limit");
        $fatal(1, "watchdog");
    end

endmodule
